// File: rtl/avg_window_sequencer.sv
// rtl/avg_window_sequencer.sv - sequences the sample averager over a run of acquisition windows (optional watchdog: AVG_SEQ_TIMEOUT_EN)
module avg_window_sequencer #(
  parameter int DATA_IN_WIDTH  = 12,
  parameter int DATA_OUT_WIDTH = 21,
  parameter int SAMPLING_RATE  = 512,
  parameter int WIN_CNT_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [WIN_CNT_WIDTH-1:0]  i_num_win,
  input  logic                      s_valid,
  input  logic [DATA_IN_WIDTH-1:0]  s_data,
  output logic                      s_ready,
  output logic                      avg_clr,
  output logic                      avg_valid,
  output logic [DATA_OUT_WIDTH-1:0] avg_data,
  input  logic                      avg_flag,
  input  logic [DATA_OUT_WIDTH-1:0] avg_result,
  output logic                      m_valid,
  output logic [DATA_OUT_WIDTH-1:0] m_data,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err
);

  // TIMEOUT_CYCLES only sizes the watchdog; the zero term keeps it referenced when the watchdog is compiled out
  localparam int SCW = $clog2(SAMPLING_RATE) + 0 * TIMEOUT_CYCLES;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_OUT} state_t;

  state_t                   state;
  logic [SCW-1:0]           samp_cnt;
  logic [WIN_CNT_WIDTH-1:0] win_idx;
  logic [WIN_CNT_WIDTH-1:0] num_win;
  logic                     accept;
  logic                     last_win;

  assign s_ready  = (state == S_RUN);
  assign accept   = s_valid & s_ready;
  assign o_busy   = (state != S_IDLE);
  assign last_win = (win_idx == num_win - WIN_CNT_WIDTH'(1));
  // the final result leaving the block ends the run; an abort in the same cycle wins
  assign o_done   = (state == S_OUT) & m_valid & m_ready & m_last & ~i_abort;

`ifdef AVG_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
`else
  assign o_err = 1'b0;
`endif

  // main sequencer: window/sample bookkeeping, averager feed, result capture and handoff
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      samp_cnt  <= '0;
      win_idx   <= '0;
      num_win   <= '0;
      avg_clr   <= 1'b0;
      avg_valid <= 1'b0;
      avg_data  <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
`ifdef AVG_SEQ_TIMEOUT_EN
      wait_cnt  <= '0;
      o_err     <= 1'b0;
`endif
    end else begin
      avg_clr   <= 1'b0;
      avg_valid <= 1'b0;
      if (state != S_IDLE && i_abort) begin
        // abort drops everything in flight, including an unread result
        state    <= S_IDLE;
        samp_cnt <= '0;
        m_valid  <= 1'b0;
        m_last   <= 1'b0;
        avg_clr  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start && !i_abort) begin
              num_win  <= (i_num_win == '0) ? WIN_CNT_WIDTH'(1) : i_num_win;
              win_idx  <= '0;
              samp_cnt <= '0;
              avg_clr  <= 1'b1;
`ifdef AVG_SEQ_TIMEOUT_EN
              o_err    <= 1'b0;
`endif
              state    <= S_RUN;
            end
          end
          S_RUN: begin
            if (accept) begin
              avg_valid <= 1'b1;
              avg_data  <= DATA_OUT_WIDTH'(s_data);
              if (samp_cnt == SCW'(SAMPLING_RATE - 1)) begin
                samp_cnt <= '0;
`ifdef AVG_SEQ_TIMEOUT_EN
                wait_cnt <= '0;
`endif
                state    <= S_WAIT;
              end else begin
                samp_cnt <= samp_cnt + SCW'(1);
              end
            end
          end
          S_WAIT: begin
            if (avg_flag) begin
              m_data  <= avg_result;
              m_valid <= 1'b1;
              m_last  <= last_win;
              state   <= S_OUT;
            end
`ifdef AVG_SEQ_TIMEOUT_EN
            else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
              o_err   <= 1'b1;
              avg_clr <= 1'b1;
              state   <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt + TW'(1);
            end
`endif
          end
          S_OUT: begin
            if (m_ready) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              if (m_last) begin
                state <= S_IDLE;
              end else begin
                win_idx <= win_idx + WIN_CNT_WIDTH'(1);
                state   <= S_RUN;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
